// File: rtl/wave_pkg.sv
// Shared encodings for the waveform output stage: source select, FSM states, default width.
package wave_pkg;

    localparam int unsigned WAVE_WIDTH = 8;

    typedef enum logic [1:0] {
        SEL_SIN  = 2'b00,
        SEL_TRI  = 2'b01,
        SEL_RECT = 2'b10,
        SEL_ZERO = 2'b11
    } sel_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10
    } state_e;

endpackage

// File: rtl/wave_pwm_presc.sv
// PWM prescaler: counts 0..presc and emits tick when the count reaches presc.
// presc is sampled live, so lowering it below the count forces an immediate tick.
module wave_pwm_presc #(
    parameter int unsigned PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] pc_q;
    logic [PRESC_W-1:0] pc_d;

    assign tick = (pc_q >= presc);

    always_comb begin
        pc_d = pc_q + PRESC_W'(1);
        if (clr || tick) begin
            pc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/wave_pwm_dac.sv
// PWM DAC output stage: source mux, power-of-two attenuation, period-aligned duty load
// and start/stop FSM. Define WAVE_PWM_COMP_EN to add pwm_n with a 1-clock dead time.
module wave_pwm_dac
    import wave_pkg::*;
#(
    parameter int unsigned WIDTH   = WAVE_WIDTH,
    parameter int unsigned PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [1:0]         sel,
    input  logic [1:0]         gain_shift,
    input  logic [PRESC_W-1:0] presc,
    input  logic [WIDTH-1:0]   in_sin,
    input  logic [WIDTH-1:0]   in_tri,
    input  logic [WIDTH-1:0]   in_rect,
    output logic               pwm_out,
`ifdef WAVE_PWM_COMP_EN
    output logic               pwm_n,
`endif
    output logic               sample_req,
    output logic [WIDTH-1:0]   duty_q,
    output logic               busy
);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] duty_d;
    logic             tick;
    logic             wrap;
    logic             load;
    logic             c;
`ifdef WAVE_PWM_COMP_EN
    logic             c_q;
`endif

    assign busy = (state_q != IDLE);
    assign wrap = busy && tick && (cnt_q == '1);
    assign c    = busy && (cnt_q < duty_q);

    // Prescaler is held cleared while idle so every run starts on a fresh tick boundary.
    wave_pwm_presc #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk   (clk),
        .rst   (rst),
        .clr   (state_q == IDLE),
        .presc (presc),
        .tick  (tick)
    );

    always_comb begin
        src = '0;
        unique case (sel_e'(sel))
            SEL_SIN:  src = in_sin;
            SEL_TRI:  src = in_tri;
            SEL_RECT: src = in_rect;
            SEL_ZERO: src = '0;
        endcase
        duty_d = src >> gain_shift;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (tick) begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
                if (wrap) begin
                    load = 1'b1;
                end
                if (!en) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (tick) begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
                // Finishing the period wins over a returning en; no reload on the way out.
                if (wrap) begin
                    state_d = IDLE;
                end else if (en) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            duty_q     <= '0;
            sample_req <= 1'b0;
            pwm_out    <= 1'b0;
`ifdef WAVE_PWM_COMP_EN
            c_q        <= 1'b0;
            pwm_n      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sample_req <= load;
            if (load) begin
                duty_q <= duty_d;
            end
`ifdef WAVE_PWM_COMP_EN
            c_q     <= c;
            pwm_out <= c & c_q;
            pwm_n   <= busy & ~c & ~c_q;
`else
            pwm_out <= c;
`endif
        end
    end

endmodule

// File: tb/tb_wave_pwm_dac.sv
// Bench for wave_pwm_dac: table of per-period vectors (fixed + random) checked against
// arithmetic expectations, plus hand sequences for reset, drain, re-arm and mid-run reset.
module tb_wave_pwm_dac;

    localparam int W  = 8;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic [1:0]    sel = '0;
    logic [1:0]    gain_shift = '0;
    logic [PW-1:0] presc = '0;
    logic [W-1:0]  in_sin = '0;
    logic [W-1:0]  in_tri = '0;
    logic [W-1:0]  in_rect = '0;
    logic          pwm_out;
    logic          sample_req;
    logic [W-1:0]  duty_q;
    logic          busy;
`ifdef WAVE_PWM_COMP_EN
    logic          pwm_n;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wave_pwm_dac #(
        .WIDTH   (W),
        .PRESC_W (PW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .sel        (sel),
        .gain_shift (gain_shift),
        .presc      (presc),
        .in_sin     (in_sin),
        .in_tri     (in_tri),
        .in_rect    (in_rect),
        .pwm_out    (pwm_out),
`ifdef WAVE_PWM_COMP_EN
        .pwm_n      (pwm_n),
`endif
        .sample_req (sample_req),
        .duty_q     (duty_q),
        .busy       (busy)
    );

    typedef struct {
        int sel;
        int gain;
        int presc;
        int vsin;
        int vtri;
        int vrect;
        int exp_duty;
        int exp_high;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Reference: pick the source, divide by 2^gain (integer division == zero-filled shift).
    function automatic int ref_duty(input int s, input int g, input int vs, input int vt,
                                    input int vr);
        int src;
        case (s)
            0:       src = vs;
            1:       src = vt;
            2:       src = vr;
            default: src = 0;
        endcase
        return src / (1 << g);
    endfunction

    task automatic do_reset(input int n);
        rst = 1'b1;
        en  = 1'b0;
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic wait_req(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (sample_req) begin
                ok = 1'b1;
                return;
            end
        end
        check({name, " sample_req timeout"}, 0, 1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        bit ok;
        int per;
        int high;
        int nreq;
        int req_at;
        int overlap;
        int both_low;
        do_reset(2);
        sel        = 2'(v.sel);
        gain_shift = 2'(v.gain);
        presc      = PW'(v.presc);
        in_sin     = W'(v.vsin);
        in_tri     = W'(v.vtri);
        in_rect    = W'(v.vrect);
        en         = 1'b1;
        wait_req(tag, ok);
        if (!ok) return;
        check({tag, " duty"}, int'(duty_q), v.exp_duty);
        per = 256 * (v.presc + 1);
        high = 0; nreq = 0; req_at = -1; overlap = 0; both_low = 0;
        for (int i = 1; i <= per; i++) begin
            step();
            high += int'(pwm_out);
            if (sample_req) begin
                nreq++;
                req_at = i;
            end
`ifdef WAVE_PWM_COMP_EN
            if (pwm_out && pwm_n) overlap++;
            if (!pwm_out && !pwm_n) both_low++;
`endif
        end
`ifdef WAVE_PWM_COMP_EN
        check({tag, " high clks"}, high, v.exp_high - ((v.exp_duty != 0) ? 1 : 0));
        check({tag, " overlap"}, overlap, 0);
        check({tag, " dead clks"}, both_low, (v.exp_duty != 0) ? 2 : 0);
`else
        check({tag, " high clks"}, high, v.exp_high);
`endif
        check({tag, " req count"}, nreq, 1);
        check({tag, " req period"}, req_at, per);
        en = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int busy_ones;
        int reqs;
        int req_k;

        vecs[0] = '{1, 0, 0,   0,  64,   0,  64,  64};
        vecs[1] = '{0, 2, 3, 200,   0,   0,  50, 200};
        vecs[2] = '{3, 0, 0, 255, 255, 255,   0,   0};
        vecs[3] = '{2, 0, 0, 255, 255,   0,   0,   0};
        vecs[4] = '{2, 0, 0,   0,   0, 255, 255, 255};
        vecs[5] = '{1, 0, 0,   0,  16,   0,  16,  16};
        for (int i = 6; i < 12; i++) begin
            vecs[i].sel   = int'($urandom_range(0, 3));
            vecs[i].gain  = int'($urandom_range(0, 3));
            vecs[i].presc = int'($urandom_range(0, 3));
            vecs[i].vsin  = int'($urandom_range(0, 255));
            vecs[i].vtri  = int'($urandom_range(0, 255));
            vecs[i].vrect = int'($urandom_range(0, 255));
            vecs[i].exp_duty = ref_duty(vecs[i].sel, vecs[i].gain, vecs[i].vsin,
                                        vecs[i].vtri, vecs[i].vrect);
            vecs[i].exp_high = vecs[i].exp_duty * (vecs[i].presc + 1);
        end

        // Reset held with en high: everything quiet, first load one clock after release.
        rst = 1'b1; en = 1'b1; sel = 2'd1; in_tri = 8'd64; presc = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset outputs", int'(pwm_out) + int'(sample_req) + int'(busy) + int'(duty_q), 0);
        end
        rst = 1'b0;
        step();
        check("first sample_req", int'(sample_req), 1);
        check("first busy", int'(busy), 1);
        check("first duty", int'(duty_q), 64);

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Drain: en dropped at cnt=100, period completes, no load at the final wrap.
        do_reset(2);
        sel = 2'd1; gain_shift = '0; presc = '0; in_tri = 8'd64; en = 1'b1;
        wait_req("drain", ok);
        repeat (100) step();
        in_tri = 8'd128; en = 1'b0;
        busy_ones = 0; reqs = 0;
        for (int k = 101; k <= 255; k++) begin
            step();
            busy_ones += int'(busy);
            reqs += int'(sample_req);
        end
        step();
        reqs += int'(sample_req);
        check("drain busy clks", busy_ones, 155);
        check("drain idle after wrap", int'(busy), 0);
        check("drain no req", reqs, 0);
        check("drain duty held", int'(duty_q), 64);
        busy_ones = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            busy_ones += int'(busy) + int'(pwm_out) + int'(sample_req);
        end
        check("idle quiet", busy_ones, 0);

        // Re-arm: en back at cnt=150 in DRAIN, reload only at the next wrap.
        en = 1'b1;
        wait_req("rearm", ok);
        check("rearm duty", int'(duty_q), 128);
        repeat (100) step();
        en = 1'b0; in_tri = 8'd32;
        reqs = 0;
        for (int k = 101; k <= 150; k++) begin
            step();
            reqs += int'(sample_req);
        end
        en = 1'b1;
        busy_ones = 0; req_k = -1;
        for (int k = 151; k <= 256; k++) begin
            step();
            busy_ones += int'(busy);
            if (sample_req) begin
                reqs++;
                req_k = k;
            end
            if (k == 255) check("rearm duty before wrap", int'(duty_q), 128);
        end
        check("rearm busy clks", busy_ones, 106);
        check("rearm req count", reqs, 1);
        check("rearm req at wrap", req_k, 256);
        check("rearm duty after wrap", int'(duty_q), 32);

        // en falls in the same cycle as a RUN wrap: load still happens, then drain a period.
        repeat (255) step();
        en = 1'b0; in_tri = 8'd8;
        step();
        check("en+wrap req", int'(sample_req), 1);
        check("en+wrap duty", int'(duty_q), 8);
        repeat (255) step();
        check("en+wrap busy at last clk", int'(busy), 1);
        step();
        check("en+wrap idle", int'(busy), 0);

        // Reset mid-period: immediate return to reset values.
        en = 1'b1;
        wait_req("midreset", ok);
        repeat (40) step();
        rst = 1'b1;
        step();
        check("midreset outputs", int'(pwm_out) + int'(sample_req) + int'(busy) + int'(duty_q), 0);
        rst = 1'b0; en = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
